// File: rtl/qc_pkg.sv
// +----------------------------------------------------------------------+
// | qc_pkg: shared complex-number type, fixed-point defaults, FSM states |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package qc_pkg;

  localparam int Q   = 6;
  localparam int WID = 8;

  // +1.0 in sign-magnitude with Q fractional bits
  localparam logic [WID-1:0] QONE = WID'(1 << Q);

  typedef struct packed {
    logic [WID-1:0] a;
    logic [WID-1:0] b;
  } complexNum;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/circuit_sequencer_gate_mem.sv
// +----------------------------------------------------------------------+
// | gate_mem: DEPTH-entry gate matrix file, sync write, registered read  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module gate_mem
  import qc_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [AW-1:0]                   wr_addr,
  input  complexNum [DIM-1:0][DIM-1:0]    wr_data,
  input  logic                            rd_en,
  input  logic [AW-1:0]                   rd_addr,
  output complexNum [DIM-1:0][DIM-1:0]    rd_data
);

  complexNum [DIM-1:0][DIM-1:0] mem [DEPTH];

  // Contents are deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/circuit_sequencer.sv
// +----------------------------------------------------------------------+
// | circuit_sequencer: steps a gate program through an external          |
// | gate-state multiplier. Optional macro: SEQ_PRELOAD_EN (init_state).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module circuit_sequencer
  import qc_pkg::*;
#(
  parameter int N     = 2,
  parameter int DEPTH = 8,
  parameter int Q     = qc_pkg::Q,
  parameter int WID   = qc_pkg::WID,
  localparam int DIM  = 1 << N,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [AW:0]                     num_gates,
  input  logic                            gate_wr_en,
  input  logic [AW-1:0]                   gate_wr_addr,
  input  complexNum [DIM-1:0][DIM-1:0]    gate_wr_data,
`ifdef SEQ_PRELOAD_EN
  input  complexNum [DIM-1:0]             init_state,
`endif
  output complexNum [DIM-1:0][DIM-1:0]    mult_gate,
  output complexNum [DIM-1:0]             mult_state,
  input  complexNum [DIM-1:0]             mult_out,
  output complexNum [DIM-1:0]             state_out,
  output logic [AW-1:0]                   gate_idx,
  output logic                            busy,
  output logic                            done
);

  localparam complexNum        ONE  = '{a: WID'(1 << Q), b: '0};
  localparam complexNum [DIM-1:0] KET0 = {{((DIM-1)*2*WID){1'b0}}, ONE};

  seq_state_t           state, next_state;
  complexNum [DIM-1:0]  state_reg;
  complexNum [DIM-1:0]  start_vec;
  logic [AW:0]          gate_cnt;
  logic [AW:0]          clamped;
  logic                 last;

`ifdef SEQ_PRELOAD_EN
  assign start_vec = init_state;
`else
  assign start_vec = KET0;
`endif

  assign clamped = (num_gates > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_gates;
  assign last    = ({1'b0, gate_idx} == gate_cnt - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (clamped == '0) ? DONE : APPLY;
      APPLY:   next_state = CAPTURE;
      CAPTURE: next_state = last ? DONE : APPLY;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= KET0;
      gate_idx  <= '0;
      gate_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_reg <= start_vec;
          gate_idx  <= '0;
          gate_cnt  <= clamped;
        end
        CAPTURE: begin
          state_reg <= mult_out;
          if (!last) gate_idx <= gate_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  gate_mem #(
    .DIM   (DIM),
    .DEPTH (DEPTH)
  ) u_gate_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (gate_wr_en && !busy),
    .wr_addr (gate_wr_addr),
    .wr_data (gate_wr_data),
    .rd_en   (state == APPLY),
    .rd_addr (gate_idx),
    .rd_data (mult_gate)
  );

  assign state_out  = state_reg;
  assign mult_state = state_reg;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_circuit_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_circuit_sequencer: directed bench with a behavioural multiplier   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_circuit_sequencer;
  import qc_pkg::*;

  typedef complexNum [3:0]      vec_t;
  typedef vec_t      [3:0]      gate_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_gates = '0;
  logic        gate_wr_en = 1'b0;
  logic [2:0]  gate_wr_addr = '0;
  gate_t       gate_wr_data = '0;
  vec_t        init_state = '0;
  gate_t       mult_gate;
  vec_t        mult_state;
  vec_t        mult_out;
  vec_t        state_out;
  logic [2:0]  gate_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int idx_log [64];
  int inject_k = -1;

  always #5 clk = ~clk;

  circuit_sequencer #(.N(2), .DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_gates    (num_gates),
    .gate_wr_en   (gate_wr_en),
    .gate_wr_addr (gate_wr_addr),
    .gate_wr_data (gate_wr_data),
`ifdef SEQ_PRELOAD_EN
    .init_state   (init_state),
`endif
    .mult_gate    (mult_gate),
    .mult_state   (mult_state),
    .mult_out     (mult_out),
    .state_out    (state_out),
    .gate_idx     (gate_idx),
    .busy         (busy),
    .done         (done)
  );

  // Stand-in for the sign-magnitude gate-state multiplier (Q=6, WID=8).
  function automatic int sm2i(logic [7:0] v);
    return v[7] ? -int'({1'b0, v[6:0]}) : int'({1'b0, v[6:0]});
  endfunction

  function automatic logic [7:0] i2sm(int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m > 127) m = 127;
    return {(v < 0) && (m != 0), m[6:0]};
  endfunction

  function automatic vec_t model_mult(gate_t g, vec_t s);
    vec_t r;
    int re, im;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      re = 0;
      im = 0;
      for (int j = 0; j < 4; j++) begin
        re += sm2i(g[i][j].a) * sm2i(s[j].a) - sm2i(g[i][j].b) * sm2i(s[j].b);
        im += sm2i(g[i][j].a) * sm2i(s[j].b) + sm2i(g[i][j].b) * sm2i(s[j].a);
      end
      r[i].a = i2sm(re / 64);
      r[i].b = i2sm(im / 64);
    end
    return r;
  endfunction

  assign mult_out = model_mult(mult_gate, mult_state);

  function automatic vec_t basis(int k);
    vec_t v;
    v = '0;
    v[k].a = 8'h40;
    return v;
  endfunction

  function automatic gate_t x_gate();
    gate_t g;
    g = '0;
    g[0][1].a = 8'h40; g[1][0].a = 8'h40;
    g[2][3].a = 8'h40; g[3][2].a = 8'h40;
    return g;
  endfunction

  function automatic gate_t h_gate();
    gate_t g;
    g = '0;
    g[0][0].a = 8'h2D; g[0][1].a = 8'h2D; g[1][0].a = 8'h2D; g[1][1].a = 8'hAD;
    g[2][2].a = 8'h2D; g[2][3].a = 8'h2D; g[3][2].a = 8'h2D; g[3][3].a = 8'hAD;
    return g;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic write_gate(input int addr, input gate_t g);
    gate_wr_en   = 1'b1;
    gate_wr_addr = 3'(addr);
    gate_wr_data = g;
    @(negedge clk);
    gate_wr_en   = 1'b0;
  endtask

  // Cycle k after the start-sampling edge; done_k = k at which done is seen.
  task automatic run(input logic [3:0] ng, input int max_k, output int done_k);
    num_gates = ng;
    start     = 1'b1;
    done_k    = -1;
    for (int i = 0; i < 64; i++) idx_log[i] = -1;
    @(negedge clk);
    for (int k = 1; k <= max_k; k++) begin
      start      = 1'b0;
      gate_wr_en = 1'b0;
      if (busy) idx_log[k] = int'(gate_idx);
      if (k == inject_k) begin
        gate_wr_en   = 1'b1;
        gate_wr_addr = 3'd3;
        gate_wr_data = '0;
        start        = 1'b1;
        num_gates    = 4'd1;
      end
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    start      = 1'b0;
    gate_wr_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int dk;
    int pulses;

    repeat (3) @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_idx", 256'(gate_idx), 256'(0));
    check("rst_gate", 256'(mult_gate), 256'(0));
    check("rst_state", 256'(state_out), 256'(basis(0)));
    reset = 1'b0;
    @(negedge clk);

    // Single X
    write_gate(0, x_gate());
    run(4'd1, 40, dk);
    check("x1_done_cyc", 256'(dk), 256'(3));
    check("x1_busy_low", 256'(busy), 256'(0));
    check("x1_state", 256'(state_out), 256'(basis(1)));
    check("x1_mstate", 256'(mult_state), 256'(basis(1)));
    check("x1_mgate", 256'(mult_gate), 256'(x_gate()));

    // Double X
    write_gate(1, x_gate());
    run(4'd2, 40, dk);
    check("x2_done_cyc", 256'(dk), 256'(5));
    check("x2_state", 256'(state_out), 256'(basis(0)));
    check("x2_idx_k1", 256'(idx_log[1]), 256'(0));
    check("x2_idx_k3", 256'(idx_log[3]), 256'(1));

    // Hadamard written in the same cycle as start
    gate_wr_en   = 1'b1;
    gate_wr_addr = 3'd0;
    gate_wr_data = h_gate();
    run(4'd1, 40, dk);
    begin
      vec_t hv;
      hv = '0;
      hv[0].a = 8'h2D;
      hv[1].a = 8'h2D;
      check("h_done_cyc", 256'(dk), 256'(3));
      check("h_state", 256'(state_out), 256'(hv));
    end

    // Empty program restores |00>
    run(4'd0, 40, dk);
    check("empty_done_cyc", 256'(dk), 256'(1));
    check("empty_state", 256'(state_out), 256'(basis(0)));

    // Clamp to 8 gates, with ignored write/start injected mid-run
    for (int s = 0; s < 8; s++) write_gate(s, x_gate());
    inject_k = 2;
    run(4'd15, 60, dk);
    inject_k = -1;
    check("clamp_done_cyc", 256'(dk), 256'(17));
    check("clamp_state", 256'(state_out), 256'(basis(0)));
    run(4'd4, 40, dk);
    check("ign_done_cyc", 256'(dk), 256'(9));
    check("ign_state", 256'(state_out), 256'(basis(0)));

    // Reset in CAPTURE of gate 1
    num_gates = 4'd2;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_state_g0", 256'(state_out), 256'(basis(1)));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_busy", 256'(busy), 256'(0));
    check("mid_state", 256'(state_out), 256'(basis(0)));
    check("mid_idx", 256'(gate_idx), 256'(0));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("mid_no_done", 256'(pulses), 256'(0));
    run(4'd3, 40, dk);
    check("rerun_done_cyc", 256'(dk), 256'(7));
    check("rerun_state", 256'(state_out), 256'(basis(1)));

`ifdef SEQ_PRELOAD_EN
    init_state = basis(3);
    run(4'd1, 40, dk);
    check("pre_done_cyc", 256'(dk), 256'(3));
    check("pre_state", 256'(state_out), 256'(basis(2)));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
